regfile_dump: RTL

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump_if.sv | 11 +
 rtl/regfile_dump.sv | 127 ++++++++++++
 2 files changed

// File: rtl/regfile_dump_if.sv
// Output beat stream of regfile_dump: one register value per beat, valid/ready handshake.
interface regfile_dump_if;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic [4:0]  dout_addr;
  logic        dout_last;

  modport master (output dout_valid, dout_data, dout_addr, dout_last, input dout_ready);
  modport slave  (input dout_valid, dout_data, dout_addr, dout_last, output dout_ready);
endinterface

// File: rtl/regfile_dump.sv
// Streams register-file entries FIRST_REG..LAST_REG out as handshaked beats.
// Optional running checksum output dump_sum when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic [4:0]     rf_rdAddr,
  input  logic [31:0]    rf_rdData,
  regfile_dump_if.master dout,
  output logic           busy,
  output logic           done
`ifdef REGFILE_DUMP_CHECKSUM_EN
  , output logic [31:0]  dump_sum
`endif
);

  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
    $error("regfile_dump: requires 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, FIN} state_e;

  state_e      state_q;
  logic [4:0]  idx_q;
  logic [4:0]  rd_addr_q;
  logic        valid_q;
  logic [31:0] data_q;
  logic [4:0]  addr_q;
  logic        last_q;
  logic        busy_q;
  logic        done_q;
  logic        accept;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  assign accept = valid_q & dout.dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // Abort overrides every transition, including a simultaneous start.
      if (abort && state_q != IDLE) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        valid_q   <= 1'b0;
        rd_addr_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q   <= ISSUE;
              idx_q     <= FIRST;
              rd_addr_q <= FIRST;
              busy_q    <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
              sum_q     <= '0;
`endif
            end
          end
          ISSUE: state_q <= WAIT;
          WAIT: begin
            state_q <= SEND;
            valid_q <= 1'b1;
            data_q  <= rf_rdData;
            addr_q  <= idx_q;
            last_q  <= (idx_q == LAST);
          end
          SEND: begin
            if (accept) begin
              valid_q <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
              sum_q   <= sum_q + data_q;
`endif
              if (idx_q == LAST) begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end else begin
                state_q   <= ISSUE;
                idx_q     <= idx_q + 5'd1;
                rd_addr_q <= idx_q + 5'd1;
              end
            end
          end
          FIN: begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            rd_addr_q <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rf_rdAddr       = rd_addr_q;
  assign dout.dout_valid = valid_q;
  assign dout.dout_data  = data_q;
  assign dout.dout_addr  = addr_q;
  assign dout.dout_last  = last_q;
  assign busy            = busy_q;
  assign done            = done_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  assign dump_sum        = sum_q;
`endif

endmodule
